cpu_write_capture: RTL and testbench

Downstream write-back stage for `simpleCPU`: captures every CPU register/memory write (`write_addr`, `write_data`) into a 16-entry shadow register file and an in-order FIFO of write records. The FIFO drains through a valid/ready port to the board display/UART formatter. The shadow file gives the bench and debug logic random read access to the last value written to each address. It also counts writes and flags FIFO overflow.

---
 rtl/cpu_write_capture.sv | 95 +++++++++
 tb/tb_cpu_write_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_write_capture.sv
// Captures CPU writes into a shadow register file and an in-order FWFT record FIFO; head visible one cycle after capture, rd_data one cycle after rd_addr.
// Drain uses valid/ready; a capture into a full FIFO with no pop that cycle is dropped and sets sticky overflow.
module cpu_write_capture #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     halt,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               write_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] shadow    [NREGS];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic capture;
    logic pop;
    logic full;
    logic push;
    logic drop;

    always_comb begin
        capture = wr_en && !halt;
        out_valid = (count != '0);
        pop  = out_valid && out_ready;
        full = (count == CNT_W'(DEPTH));
        // A pop frees the head slot in the same edge, so a full FIFO can still accept.
        push = capture && (!full || pop);
        drop = capture && full && !pop;
        out_addr = out_valid ? fifo_addr[rd_ptr] : '0;
        out_data = out_valid ? fifo_data[rd_ptr] : '0;
    end

    // Record storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_addr[wr_ptr] <= write_addr;
            fifo_data[wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow[ADDR_W'(i)] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            write_count <= 8'd0;
            rd_data     <= '0;
        end else begin
            rd_data <= shadow[rd_addr];
            if (capture) begin
                shadow[write_addr] <= write_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            if (capture && write_count != 8'hFF) begin
                write_count <= write_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_write_capture.sv
// Directed bench: stimulus pushes accepted records into a queue, a negedge monitor pops and compares on every drain handshake.
module tb_cpu_write_capture;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       halt = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] write_addr = '0;
    logic [7:0] write_data = '0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       out_valid;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic       overflow;
    logic [7:0] write_count;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [11:0] exp_q[$];

    cpu_write_capture #(.DEPTH(4), .ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .halt(halt), .wr_en(wr_en),
        .write_addr(write_addr), .write_data(write_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready), .count(count), .overflow(overflow),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [3:0] a, input logic [7:0] d, input bit accepted);
        wr_en = 1'b1;
        write_addr = a;
        write_data = d;
        if (accepted) exp_q.push_back({a, d});
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, out_valid}, 32'd0);
        chk({name, "_q_empty"}, exp_q.size(), 32'd0);
        out_ready = 1'b0;
    endtask

    // Monitor: inputs are stable from posedge+1 to the next posedge, so a
    // handshake seen at negedge is the pop that the next edge performs.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {20'd0, out_addr, out_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("pop_record", {20'd0, out_addr, out_data}, {20'd0, exp_q.pop_front()});
                end
            end else if (!out_valid) begin
                chk("idle_head_zero", {20'd0, out_addr, out_data}, 32'd0);
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_write_count", write_count, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick();
            chk("rst_shadow", rd_data, 0);
        end

        // Single write and drain
        cap(4'd3, 8'hA5, 1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_addr", out_addr, 3);
        chk("single_data", out_data, 8'hA5);
        chk("single_count", count, 1);
        rd_addr = 4'd3;
        tick();
        chk("single_rd", rd_data, 8'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_count_after", count, 0);
        chk("single_valid_after", out_valid, 0);

        // Fill and overflow
        do_reset();
        for (int i = 0; i < 5; i++) cap(4'(i), 8'(8'h10 + i), i < 4);
        chk("fill_count", count, 4);
        chk("fill_overflow", overflow, 1);
        chk("fill_write_count", write_count, 5);
        rd_addr = 4'd4;
        tick();
        chk("fill_shadow4", rd_data, 8'h14);
        drain("fill_drain");

        // Full with simultaneous push/pop
        do_reset();
        for (int i = 0; i < 4; i++) cap(4'(8 + i), 8'(8'h20 + i), 1'b1);
        chk("full_count", count, 4);
        out_ready = 1'b1;
        cap(4'd7, 8'h77, 1'b1);
        chk("pushpop_count", count, 4);
        chk("pushpop_overflow", overflow, 0);
        drain("pushpop_drain");

        // Halt suppression
        do_reset();
        cap(4'd1, 8'h31, 1'b1);
        cap(4'd2, 8'h32, 1'b1);
        halt = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            write_addr = 4'd1;
            write_data = 8'(8'h80 + i);
            out_ready = (i < 2);
            tick();
        end
        out_ready = 1'b0;
        chk("halt_count", count, 0);
        chk("halt_write_count", write_count, 2);
        rd_addr = 4'd1;
        tick();
        chk("halt_shadow", rd_data, 8'h31);
        halt = 1'b0;
        cap(4'd5, 8'h55, 1'b1);
        chk("resume_count", count, 1);
        chk("resume_write_count", write_count, 3);
        rd_addr = 4'd6;
        cap(4'd6, 8'h66, 1'b1);
        chk("rbw_old", rd_data, 0);
        tick();
        chk("rbw_new", rd_data, 8'h66);
        drain("halt_drain");

        // Saturation and mid-operation reset
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) cap(4'(i), 8'(i), 1'b1);
        chk("sat_write_count", write_count, 255);
        chk("sat_overflow", overflow, 0);
        drain("sat_drain");
        for (int i = 0; i < 3; i++) cap(4'(i), 8'(8'hC0 + i), 1'b1);
        chk("pre_reset_count", count, 3);
        do_reset();
        chk("midrst_count", count, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_write_count", write_count, 0);

        tick();
        chk("final_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
